// File: rtl/fd_dram_slave.sv
// AXI4-Lite DRAM model: 64-bit x DEPTH word array behind the FD bridge, one transaction at a time.
// Latency: AR_VALID seen -> R_VALID after 2+READ_LAT cycles; W handshake -> B_VALID after 1+WRITE_LAT cycles.
// Backpressure: R/B held stable until R_READY/B_READY; new AR/AW ignored until the FSM is back in S_IDLE.
//
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   AR_VALID/AR_ADDR/AR_READY     read-address channel (17-bit byte address)
//   R_VALID/R_DATA/R_RESP/R_READY read-data channel (OKAY=2'b00, SLVERR=2'b10)
//   AW_VALID/AW_ADDR/AW_READY     write-address channel
//   W_VALID/W_DATA/W_READY        write-data channel (64-bit dram_data word, stored verbatim)
//   B_VALID/B_RESP/B_READY        write-response channel
// All outputs come straight from flops; nothing combinational reaches a port.
// INIT_FILE names a preload image for simulation environments that load the
// array externally; the RTL itself never clears or preloads the array.

module fd_dram_slave #(
    parameter logic [16:0] BASE_ADDR = 17'h10000,
    parameter int          DEPTH     = 256,
    parameter int          READ_LAT  = 3,
    parameter int          WRITE_LAT = 3,
    parameter string       INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,
    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,
    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,
    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,
    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY
);

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_RLAT, S_R, S_AW, S_W, S_WLAT, S_B
    } state_t;

    localparam int          IDX_W     = $clog2(DEPTH);
    localparam logic [17:0] ADDR_END  = 18'(BASE_ADDR) + 18'(8 * DEPTH);
    // The counter holds "cycles remaining minus one" so the latency state lasts exactly LAT cycles.
    localparam logic [3:0]  RLAT_LOAD = 4'((READ_LAT  > 0) ? READ_LAT  - 1 : 0);
    localparam logic [3:0]  WLAT_LOAD = 4'((WRITE_LAT > 0) ? WRITE_LAT - 1 : 0);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [16:0]       addr_q;
    logic [63:0]       wdata_q;
    logic [63:0]       mem_q [DEPTH];

    logic              ar_ready_q, r_valid_q, aw_ready_q, w_ready_q, b_valid_q;
    logic [63:0]       r_data_q;
    logic [1:0]        r_resp_q, b_resp_q;

    logic [16:0]       dec_addr;
    logic              addr_ok;
    logic [IDX_W-1:0]  idx;
    logic              enter_r, enter_b, mem_we;
    logic [63:0]       wr_word;

    // With READ_LAT=0 the read data is captured on the same edge that would
    // latch the address, so decode straight from the port while in S_AR.
    always_comb begin
        dec_addr = (state_q == S_AR) ? AR_ADDR : addr_q;
        addr_ok  = ({1'b0, dec_addr} >= 18'(BASE_ADDR)) &&
                   ({1'b0, dec_addr} <  ADDR_END) &&
                   (dec_addr[2:0] == 3'b000);
        idx      = IDX_W'((dec_addr - BASE_ADDR) >> 3);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (AR_VALID) begin
                    state_d = S_AR;
                end else if (AW_VALID) begin
                    state_d = S_AW;
                end
            end
            S_AR: begin
                if (READ_LAT == 0) begin
                    state_d = S_R;
                end else begin
                    state_d = S_RLAT;
                    cnt_d   = RLAT_LOAD;
                end
            end
            S_RLAT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_R;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_R: begin
                if (R_READY) begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                state_d = S_W;
            end
            S_W: begin
                if (W_VALID) begin
                    if (WRITE_LAT == 0) begin
                        state_d = S_B;
                    end else begin
                        state_d = S_WLAT;
                        cnt_d   = WLAT_LOAD;
                    end
                end
            end
            S_WLAT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_B;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_B: begin
                if (B_READY) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        enter_r = (state_q != S_R) && (state_d == S_R);
        enter_b = (state_q != S_B) && (state_d == S_B);
        // With WRITE_LAT=0 the commit edge is the W handshake itself.
        wr_word = (state_q == S_W) ? W_DATA : wdata_q;
        // A reset on the commit edge aborts the write.
        mem_we  = rst_n && enter_b && addr_ok;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 17'd0;
            wdata_q    <= 64'd0;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            r_data_q   <= 64'd0;
            r_resp_q   <= 2'b00;
            b_resp_q   <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ar_ready_q <= (state_d == S_AR);
            r_valid_q  <= (state_d == S_R);
            aw_ready_q <= (state_d == S_AW);
            w_ready_q  <= (state_d == S_W);
            b_valid_q  <= (state_d == S_B);
            if (state_q == S_AR) begin
                addr_q <= AR_ADDR;
            end else if (state_q == S_AW) begin
                addr_q <= AW_ADDR;
            end
            if ((state_q == S_W) && W_VALID) begin
                wdata_q <= W_DATA;
            end
            if (enter_r) begin
                r_data_q <= addr_ok ? mem_q[idx] : 64'd0;
                r_resp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (enter_b) begin
                b_resp_q <= addr_ok ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // The array is deliberately outside the reset domain: reset never clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[idx] <= wr_word;
        end
    end

    assign AR_READY = ar_ready_q;
    assign R_VALID  = r_valid_q;
    assign R_DATA   = r_data_q;
    assign R_RESP   = r_resp_q;
    assign AW_READY = aw_ready_q;
    assign W_READY  = w_ready_q;
    assign B_VALID  = b_valid_q;
    assign B_RESP   = b_resp_q;

endmodule

// File: tb/tb_fd_dram_slave.sv
// Bench for fd_dram_slave: drivers plan each transaction's expected per-cycle
// outputs from the timing rules, a word-array model supplies data, and one
// compare process checks every output on every falling edge.

module tb_fd_dram_slave;

    localparam int RL   = 3;
    localparam int WL   = 3;
    localparam int MAXC = 40000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        AR_VALID, AR_READY, R_VALID, R_READY;
    logic [16:0] AR_ADDR, AW_ADDR;
    logic [63:0] R_DATA, W_DATA;
    logic [1:0]  R_RESP, B_RESP;
    logic        AW_VALID, AW_READY, W_VALID, W_READY, B_VALID, B_READY;

    always #5 clk = ~clk;

    fd_dram_slave #(
        .BASE_ADDR(17'h10000), .DEPTH(256), .READ_LAT(RL), .WRITE_LAT(WL), .INIT_FILE("")
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    // cyc = number of rising edges so far; "cycle k" is the interval after edge k.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected-output timeline, all zero unless a transaction plans otherwise.
    bit          e_ar [MAXC];
    bit          e_rv [MAXC];
    bit          e_aw [MAXC];
    bit          e_wr [MAXC];
    bit          e_bv [MAXC];
    logic [63:0] e_rd [MAXC];
    logic [1:0]  e_rr [MAXC];
    logic [1:0]  e_br [MAXC];

    logic [63:0] mdl [256];
    int          n_cmp  = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;

    function automatic bit legal(input int a);
        return (a >= 32'h10000) && (a < 32'h10000 + 8 * 256) && (a % 8 == 0);
    endfunction

    function automatic int widx(input int a);
        return (a - 32'h10000) / 8;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && cyc < MAXC) begin
            chk("AR_READY", {63'd0, AR_READY}, {63'd0, e_ar[cyc]});
            chk("R_VALID",  {63'd0, R_VALID},  {63'd0, e_rv[cyc]});
            chk("AW_READY", {63'd0, AW_READY}, {63'd0, e_aw[cyc]});
            chk("W_READY",  {63'd0, W_READY},  {63'd0, e_wr[cyc]});
            chk("B_VALID",  {63'd0, B_VALID},  {63'd0, e_bv[cyc]});
            if (e_rv[cyc]) begin
                chk("R_DATA", R_DATA, e_rd[cyc]);
                chk("R_RESP", {62'd0, R_RESP}, {62'd0, e_rr[cyc]});
            end
            if (e_bv[cyc]) begin
                chk("B_RESP", {62'd0, B_RESP}, {62'd0, e_br[cyc]});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AR_VALID driven in cycle k is seen at edge k+1: AR_READY in cycle k+1,
    // R_VALID from cycle k+2+RL until the cycle R_READY is driven.
    task automatic do_read(input logic [16:0] addr, input int stall, input bit with_aw,
                           output logic [63:0] got_d, output logic [1:0] got_r);
        int k, s;
        logic [63:0] d;
        logic [1:0]  rr;
        k = cyc;
        if (legal(int'(addr))) begin
            d  = mdl[widx(int'(addr))];
            rr = 2'b00;
        end else begin
            d  = 64'd0;
            rr = 2'b10;
        end
        e_ar[k+1] = 1'b1;
        s = k + 2 + RL;
        for (int i = s; i <= s + stall; i++) begin
            e_rv[i] = 1'b1;
            e_rd[i] = d;
            e_rr[i] = rr;
        end
        AR_ADDR  = addr;
        AR_VALID = 1'b1;
        if (with_aw) AW_VALID = 1'b1;
        tick();
        tick();
        AR_VALID = 1'b0;
        while (cyc < s + stall) tick();
        R_READY = 1'b1;
        got_d   = R_DATA;
        got_r   = R_RESP;
        tick();
        R_READY = 1'b0;
    endtask

    // AW_READY in cycle k+1, W_READY from k+2 until W_VALID (driven in k+2+wd),
    // B_VALID from k+3+wd+WL until the cycle B_READY is driven.
    task automatic do_write(input logic [16:0] addr, input logic [63:0] data, input int wd,
                            input int bstall, output logic [1:0] got_b);
        int k, sb;
        bit ok;
        k  = cyc;
        ok = legal(int'(addr));
        e_aw[k+1] = 1'b1;
        for (int i = k + 2; i <= k + 2 + wd; i++) e_wr[i] = 1'b1;
        sb = k + 3 + wd + WL;
        for (int i = sb; i <= sb + bstall; i++) begin
            e_bv[i] = 1'b1;
            e_br[i] = ok ? 2'b00 : 2'b10;
        end
        AW_ADDR  = addr;
        AW_VALID = 1'b1;
        tick();
        tick();
        AW_VALID = 1'b0;
        while (cyc < k + 2 + wd) tick();
        W_DATA  = data;
        W_VALID = 1'b1;
        tick();
        W_VALID = 1'b0;
        W_DATA  = {$urandom, $urandom};
        while (cyc < sb + bstall) tick();
        B_READY = 1'b1;
        got_b   = B_RESP;
        tick();
        B_READY = 1'b0;
        if (ok) mdl[widx(int'(addr))] = data;
    endtask

    initial begin
        #(MAXC * 10);
        $display("FAIL watchdog: simulation exceeded %0d cycles", MAXC);
        $fatal(1);
    end

    initial begin
        logic [63:0] d, wv;
        logic [1:0]  r, b;
        logic [16:0] a;
        logic [16:0] bad [3];
        int          k, kind;

        rst_n = 1'b0;
        AR_VALID = 1'b0; AR_ADDR = '0; R_READY = 1'b0;
        AW_VALID = 1'b0; AW_ADDR = '0; W_VALID = 1'b0; W_DATA = '0; B_READY = 1'b0;
        tick();
        chk_en = 1'b1;
        chk("reset R_DATA", R_DATA, 64'd0);
        chk("reset R_RESP", {62'd0, R_RESP}, 64'd0);
        chk("reset B_RESP", {62'd0, B_RESP}, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Fill every entry so later reads have defined contents.
        for (int i = 0; i < 256; i++) begin
            do_write(17'h10000 + 17'(8 * i), {$urandom, $urandom}, 0, 0, b);
        end

        // Entry 5 read.
        do_write(17'h10028, 64'h0123_4567_89AB_CDEF, 0, 0, b);
        chk("wr entry5 B_RESP", {62'd0, b}, 64'd0);
        do_read(17'h10028, 0, 1'b0, d, r);
        chk("rd entry5 data", d, 64'h0123_4567_89AB_CDEF);
        chk("rd entry5 resp", {62'd0, r}, 64'd0);

        // Last entry write then read back.
        do_write(17'h107F8, 64'hDEAD_BEEF_0000_00FF, 1, 0, b);
        chk("wr entry255 B_RESP", {62'd0, b}, 64'd0);
        do_read(17'h107F8, 0, 1'b0, d, r);
        chk("rd entry255 data", d, 64'hDEAD_BEEF_0000_00FF);

        // Misaligned, below range, above range.
        bad[0] = 17'h10004; bad[1] = 17'h0FFF8; bad[2] = 17'h10800;
        for (int i = 0; i < 3; i++) begin
            do_write(bad[i], 64'hBAD0_BAD0_BAD0_BAD0, 0, 0, b);
            chk("illegal wr B_RESP", {62'd0, b}, 64'd2);
            do_read(bad[i], 0, 1'b0, d, r);
            chk("illegal rd data", d, 64'd0);
            chk("illegal rd resp", {62'd0, r}, 64'd2);
        end
        do_read(17'h10000, 0, 1'b0, d, r);
        chk("entry0 untouched", d, mdl[0]);
        do_read(17'h10000, 0, 1'b0, d, r);
        do_read(17'h107F8, 0, 1'b0, d, r);
        chk("entry255 untouched", d, 64'hDEAD_BEEF_0000_00FF);

        // AR and AW in the same cycle: read first, AW_READY held low until after R.
        AW_ADDR = 17'h10100;
        do_read(17'h10010, 2, 1'b1, d, r);
        do_write(17'h10100, 64'h5555_AAAA_1234_5678, 1, 0, b);
        do_read(17'h10100, 0, 1'b0, d, r);
        chk("simul write readback", d, 64'h5555_AAAA_1234_5678);

        // Seven-cycle backpressure on both response channels.
        do_read(17'h10028, 7, 1'b0, d, r);
        chk("stalled rd data", d, 64'h0123_4567_89AB_CDEF);
        do_write(17'h10030, 64'hCAFE_F00D_0BAD_BEEF, 0, 7, b);
        chk("stalled wr B_RESP", {62'd0, b}, 64'd0);

        // Reset during the write latency of entry 9: no commit, outputs cleared.
        k = cyc;
        e_aw[k+1] = 1'b1;
        e_wr[k+2] = 1'b1;
        AW_ADDR  = 17'h10048;
        AW_VALID = 1'b1;
        tick();
        tick();
        AW_VALID = 1'b0;
        W_DATA   = 64'hFFFF_0000_FFFF_0000;
        W_VALID  = 1'b1;
        tick();
        W_VALID  = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        chk("abort R_DATA", R_DATA, 64'd0);
        chk("abort B_RESP", {62'd0, B_RESP}, 64'd0);
        rst_n = 1'b1;
        tick();
        do_read(17'h10048, 0, 1'b0, d, r);
        chk("entry9 kept", d, mdl[9]);

        // Random traffic.
        for (int n = 0; n < 100; n++) begin
            repeat ($urandom_range(0, 3)) tick();
            kind = $urandom_range(0, 9);
            if (kind < 8)       a = 17'h10000 + 17'(8 * $urandom_range(0, 255));
            else if (kind == 8) a = 17'h10000 + 17'(8 * $urandom_range(0, 255)) + 17'($urandom_range(1, 7));
            else if ($urandom_range(0, 1) == 0) a = 17'h10000 - 17'(8 * $urandom_range(1, 64));
            else                a = 17'h10800 + 17'(8 * $urandom_range(0, 64));
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, $urandom_range(0, 4), 1'b0, d, r);
            end else begin
                wv = {$urandom, $urandom};
                do_write(a, wv, $urandom_range(0, 3), $urandom_range(0, 4), b);
            end
        end
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
